// File: rtl/ex_mem_pkg.sv
// Shared constants for the EX/MEM stage register: m_i bit indices and default widths.
package ex_mem_pkg;

    localparam int unsigned MEM_WR_BIT = 0;
    localparam int unsigned MEM_RD_BIT = 1;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned RD_W_DEF   = 5;
    localparam int unsigned WB_W_DEF   = 2;

endpackage

// File: rtl/ex_mem_stage_reg_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register with valid bit, stall/flush and multi-cycle memory back-pressure.
// Optional performance counters (hold/bubble) are built when EX_MEM_PERF_EN is defined.
module ex_mem_stage_reg
    import ex_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RD_W   = RD_W_DEF,
    parameter int unsigned WB_W   = WB_W_DEF,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    input  logic [WB_W-1:0]   wb_i,
    input  logic [1:0]        m_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] fw2_i,
    input  logic [RD_W-1:0]   rd_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              mem_ready_i,
    output logic              valid_o,
    output logic [WB_W-1:0]   wb_o,
    output logic              memwrite_o,
    output logic              memread_o,
    output logic [DATA_W-1:0] alu_o,
    output logic [DATA_W-1:0] fw2_o,
    output logic [RD_W-1:0]   rd_o,
    output logic              busy_o
`ifdef EX_MEM_PERF_EN
    ,
    output logic [CNT_W-1:0]  hold_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic mem_op;
    logic en;
    logic load_bubble;

    // busy_o depends only on registered state and mem_ready_i, never on EX inputs
    assign mem_op      = valid_o & (memread_o | memwrite_o);
    assign busy_o      = mem_op & ~mem_ready_i;
    assign en          = ~stall_i & ~busy_o;
    assign load_bubble = flush_i | ~valid_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_o    <= 1'b0;
            wb_o       <= '0;
            memwrite_o <= 1'b0;
            memread_o  <= 1'b0;
            alu_o      <= '0;
            fw2_o      <= '0;
            rd_o       <= '0;
        end else if (en) begin
            if (load_bubble) begin
                valid_o    <= 1'b0;
                wb_o       <= '0;
                memwrite_o <= 1'b0;
                memread_o  <= 1'b0;
                alu_o      <= '0;
                fw2_o      <= '0;
                rd_o       <= '0;
            end else begin
                valid_o    <= 1'b1;
                wb_o       <= wb_i;
                memwrite_o <= m_i[MEM_WR_BIT];
                memread_o  <= m_i[MEM_RD_BIT];
                alu_o      <= alu_i;
                fw2_o      <= fw2_i;
                rd_o       <= rd_i;
            end
        end
    end

`ifdef EX_MEM_PERF_EN
    logic hold_inc;
    logic bubble_inc;

    assign hold_inc   = ~en & valid_o;
    assign bubble_inc = en & load_bubble;

    sat_counter #(.W(CNT_W)) u_hold_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (hold_inc),
        .cnt_o   (hold_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (bubble_inc),
        .cnt_o   (bubble_cnt_o)
    );
`endif

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Self-checking bench for ex_mem_stage_reg: directed scenarios plus random traffic vs. a reference model.
module tb_ex_mem_stage_reg;

    localparam int unsigned DW  = 32;
    localparam int unsigned RW  = 5;
    localparam int unsigned WBW = 2;
    localparam int unsigned CW  = 4;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          valid_i;
    logic [WBW-1:0] wb_i;
    logic [1:0]    m_i;
    logic [DW-1:0] alu_i;
    logic [DW-1:0] fw2_i;
    logic [RW-1:0] rd_i;
    logic          stall_i;
    logic          flush_i;
    logic          mem_ready_i;
    logic          valid_o;
    logic [WBW-1:0] wb_o;
    logic          memwrite_o;
    logic          memread_o;
    logic [DW-1:0] alu_o;
    logic [DW-1:0] fw2_o;
    logic [RW-1:0] rd_o;
    logic          busy_o;
`ifdef EX_MEM_PERF_EN
    logic [CW-1:0] hold_cnt_o;
    logic [CW-1:0] bubble_cnt_o;
`endif

    ex_mem_stage_reg #(
        .DATA_W (DW),
        .RD_W   (RW),
        .WB_W   (WBW),
        .CNT_W  (CW)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .valid_i     (valid_i),
        .wb_i        (wb_i),
        .m_i         (m_i),
        .alu_i       (alu_i),
        .fw2_i       (fw2_i),
        .rd_i        (rd_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .mem_ready_i (mem_ready_i),
        .valid_o     (valid_o),
        .wb_o        (wb_o),
        .memwrite_o  (memwrite_o),
        .memread_o   (memread_o),
        .alu_o       (alu_o),
        .fw2_o       (fw2_o),
        .rd_o        (rd_o),
        .busy_o      (busy_o)
`ifdef EX_MEM_PERF_EN
        ,
        .hold_cnt_o   (hold_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: what the stage should be holding
    bit              m_valid;
    bit [WBW-1:0]    m_wb;
    bit              m_mw;
    bit              m_mr;
    bit [DW-1:0]     m_alu;
    bit [DW-1:0]     m_fw2;
    bit [RW-1:0]     m_rd;
    int unsigned     m_hold;
    int unsigned     m_bub;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_valid = 0; m_wb = '0; m_mw = 0; m_mr = 0;
        m_alu = '0; m_fw2 = '0; m_rd = '0; m_hold = 0; m_bub = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, DW'(valid_o),    DW'(m_valid));
        check({tag, ".wb"},    DW'(wb_o),       DW'(m_wb));
        check({tag, ".mw"},    DW'(memwrite_o), DW'(m_mw));
        check({tag, ".mr"},    DW'(memread_o),  DW'(m_mr));
        check({tag, ".alu"},   alu_o,           m_alu);
        check({tag, ".fw2"},   fw2_o,           m_fw2);
        check({tag, ".rd"},    DW'(rd_o),       DW'(m_rd));
`ifdef EX_MEM_PERF_EN
        check({tag, ".hold"},  DW'(hold_cnt_o),   DW'(m_hold));
        check({tag, ".bub"},   DW'(bubble_cnt_o), DW'(m_bub));
`endif
    endtask

    task automatic drive(input bit v, input bit [1:0] m, input bit [DW-1:0] alu,
                         input bit [RW-1:0] rd, input bit stall, input bit flush, input bit rdy);
        valid_i     = v;
        m_i         = m;
        alu_i       = alu;
        fw2_i       = ~alu;
        rd_i        = rd;
        wb_i        = WBW'(rd);
        stall_i     = stall;
        flush_i     = flush;
        mem_ready_i = rdy;
    endtask

    // One clock: inputs already driven (negedge); check busy, advance model, check outputs.
    task automatic step(input string tag);
        bit busy_exp, adv;
        #1;
        busy_exp = m_valid && (m_mw || m_mr) && !mem_ready_i;
        check({tag, ".busy"}, DW'(busy_o), DW'(busy_exp));
        adv = !stall_i && !busy_exp;
        @(posedge clk_i);
        if (!adv) begin
            if (m_valid && m_hold < CNT_MAX) m_hold++;
        end else if (flush_i || !valid_i) begin
            m_valid = 0; m_wb = '0; m_mw = 0; m_mr = 0;
            m_alu = '0; m_fw2 = '0; m_rd = '0;
            if (m_bub < CNT_MAX) m_bub++;
        end else begin
            m_valid = 1; m_wb = wb_i; m_mw = m_i[0]; m_mr = m_i[1];
            m_alu = alu_i; m_fw2 = fw2_i; m_rd = rd_i;
        end
        #1;
        check_outputs(tag);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        drive(1, 2'b11, 32'hDEAD_BEEF, 5'd31, 0, 0, 0);
        rst_n_i = 1'b0;
        model_clear();
        #1;
        check_outputs("reset");
        check("reset.busy", DW'(busy_o), 0);
        @(negedge clk_i);
        check_outputs("reset_hold");
        rst_n_i = 1'b1;
    endtask

    initial begin
        rst_n_i = 1'b1;
        drive(0, 2'b00, '0, '0, 0, 0, 1);
        model_clear();
        do_reset();

        // First instruction after reset
        drive(1, 2'b00, 32'h0000_0040, 5'd5, 0, 0, 1);
        step("first");
        check("first.alu_const", alu_o, 32'h40);
        check("first.rd_const", DW'(rd_o), 5);

        // Load waiting 3 cycles on memory, EX inputs changing underneath
        drive(1, 2'b10, 32'h0000_1000, 5'd7, 0, 0, 0);
        step("load_cap");
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b00, 32'h2000 + i, 5'd9, 0, 0, 0);
            step("load_wait");
            check("load_wait.alu_frozen", alu_o, 32'h1000);
        end
        drive(1, 2'b00, 32'h0000_3000, 5'd10, 0, 0, 1);
        step("load_done");
        check("load_done.next_alu", alu_o, 32'h3000);

        // Hazard stall for 2 cycles
        for (int i = 0; i < 2; i++) begin
            drive(1, 2'b01, 32'h4000 + i, 5'd11, 1, 0, 1);
            step("stall");
        end
        drive(1, 2'b00, 32'h0000_5000, 5'd12, 0, 0, 1);
        step("stall_rel");

        // Flush of an incoming store
        drive(1, 2'b01, 32'h0000_6000, 5'd13, 0, 1, 1);
        step("flush");

        // Flush ignored while a store waits on memory
        drive(1, 2'b01, 32'h0000_7000, 5'd14, 0, 0, 0);
        step("st_cap");
        drive(1, 2'b00, 32'h0000_8000, 5'd15, 0, 1, 0);
        step("st_flush_busy");
        check("st_flush_busy.mw_kept", DW'(memwrite_o), 1);
        drive(1, 2'b00, 32'h0000_9000, 5'd16, 0, 0, 1);
        step("st_done");

        // Non-memory ops advance regardless of mem_ready_i
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b00, 32'hA000 + i, 5'(17 + i), 0, 0, 0);
            step("nonmem");
        end

        // Reset in the middle of a pending access
        drive(1, 2'b10, 32'h0000_B000, 5'd20, 0, 0, 0);
        step("mid_cap");
        #3 rst_n_i = 1'b0;
        model_clear();
        #1;
        check_outputs("mid_reset");
        check("mid_reset.busy", DW'(busy_o), 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Counter scenario from a fresh reset
        do_reset();
        drive(1, 2'b00, 32'h0000_C000, 5'd21, 0, 0, 1);
        step("cnt_cap");
        for (int i = 0; i < 20; i++) begin
            drive(1, 2'b00, 32'hC100 + i, 5'd22, 1, 0, 1);
            step("cnt_hold");
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b00, 32'hC200 + i, 5'd23, 0, 1, 1);
            step("cnt_flush");
        end
`ifdef EX_MEM_PERF_EN
        check("cnt.hold_sat", DW'(hold_cnt_o), 15);
        check("cnt.bubbles", DW'(bubble_cnt_o), 3);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), 2'($urandom), $urandom, 5'($urandom),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 1) == 0));
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule

// File: doc/ex_mem_stage_reg.md
# ex_mem_stage_reg

Parametrised EX/MEM pipeline stage register for the five-stage CPU, carrying WB controls, memory controls, ALU result, store data (fw2) and destination register from EX into MEM. Unlike the fixed-width free-running latch of the previous generation, it has:
- a valid bit;
- hazard-unit stall and branch flush;
- a ready handshake with a multi-cycle data memory, which holds the stage and back-pressures EX.

## Interface
Parameters:
- DATA_W, 32, width of ALU result and store data
- RD_W, 5, destination register index width
- WB_W, 2, width of write-back control bundle
- CNT_W, 16, performance counter width (only with EX_MEM_PERF_EN)

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- valid_i  in  1  EX holds a real instruction
- wb_i  in  WB_W  write-back controls
- m_i  in  2  memory controls, bit0 = MemWrite, bit1 = MemRead
- alu_i  in  DATA_W  ALU result / memory address
- fw2_i  in  DATA_W  forwarded rs2 (store data)
- rd_i  in  RD_W  destination register
- stall_i  in  1  hazard-unit stall, hold stage
- flush_i  in  1  discard instruction entering from EX
- mem_ready_i  in  1  data memory completes access this cycle
- valid_o  out  1  stage holds a real instruction
- wb_o  out  WB_W  registered wb_i
- memwrite_o, memread_o  out  1 each  registered m_i[0], m_i[1]
- alu_o, fw2_o  out  DATA_W  registered data
- rd_o  out  RD_W  registered rd_i
- busy_o  out  1  stage blocked on memory, upstream must stall
- hold_cnt_o, bubble_cnt_o  out  CNT_W  counters (only with EX_MEM_PERF_EN)

## Operation
- mem_op = valid_o & (memread_o | memwrite_o).
- busy_o = mem_op & ~mem_ready_i.
- en = ~stall_i & ~busy_o.
- Priority on each rising edge:
  - en=0: all registers hold. flush_i is ignored, because the upstream stage holds and re-presents the flush.
  - en=1, flush_i=1: load a bubble. valid_o, wb_o, memwrite_o, memread_o, alu_o, fw2_o and rd_o all become 0.
  - en=1, flush_i=0, valid_i=0: load a bubble (same as above).
  - en=1, flush_i=0, valid_i=1: load all inputs. memwrite_o=m_i[0], memread_o=m_i[1].
- A non-memory instruction (mem_op=0) never asserts busy_o; mem_ready_i is don't-care for it.
- Reset mid-access abandons the access; outputs clear immediately.

## Timing
- Reset: every output register is 0 (valid_o, wb_o, memwrite_o, memread_o, alu_o, fw2_o, rd_o, counters). busy_o is therefore 0.
- Latency: 1 cycle from inputs to outputs when en=1.
- busy_o is combinational from registered state and mem_ready_i; it has no path from EX inputs.
- Memory handshake:
  - The access is presented while mem_op=1.
  - It completes in the cycle mem_ready_i=1.
  - The next instruction is captured on that same edge.
  - A zero-wait memory ties mem_ready_i=1, giving full throughput.
- stall_i and busy_o together: hold (the same as either alone).
- Outputs stay stable for the whole hold, so the memory sees a constant address and data.

## Configuration
- EX_MEM_PERF_EN defined: hold_cnt_o and bubble_cnt_o exist.
  - hold_cnt_o increments every cycle en=0 with valid_o=1.
  - bubble_cnt_o increments every cycle en=1 that loads a bubble.
  - Both saturate at all-ones and never wrap.
  - Both are cleared by reset only.
- EX_MEM_PERF_EN undefined: the counter ports and logic are absent; all other behaviour is identical.

## Structure
- Shared package ex_mem_pkg:
  - MEM_WR_BIT=0 and MEM_RD_BIT=1 indices for m_i.
  - Default width constants DATA_W_DEF, RD_W_DEF, WB_W_DEF.
- One sub-module, sat_counter (width parameter; increment enable; saturates at all-ones; asynchronous active-low clear). It is instantiated twice under EX_MEM_PERF_EN.

## Test plan
- Reset with inputs nonzero -> all outputs 0 while rst_n_i=0. First edge after release with valid_i=1, alu_i=0x0000_0040, rd_i=5 -> valid_o=1, alu_o=0x40, rd_o=5.
- Load (m_i=2'b10) captured, mem_ready_i=0 for 3 cycles -> busy_o=1 for 3 cycles with outputs frozen. Cycle 4 with mem_ready_i=1 -> busy_o=0 and the next instruction is captured on that edge.
- stall_i=1 for 2 cycles while EX inputs change -> outputs unchanged. stall_i=0 -> current inputs captured.
- flush_i=1 with valid_i=1, m_i=2'b01 -> next cycle valid_o=0, memwrite_o=0, rd_o=0. flush_i=1 while busy_o=1 -> stored store remains and completes.
- Non-memory op (m_i=0) with mem_ready_i=0 -> busy_o=0 and the stage advances each cycle.
- EX_MEM_PERF_EN with CNT_W=4: 20 held cycles with valid_o=1 -> hold_cnt_o=15 (saturated). 3 flushes -> bubble_cnt_o=3.
